tt_response_checker: RTL

//  Synthesizable receive-side scoreboard for combinational DUT tests. Watches the stimulus vector

---
 rtl/tt_check_pkg.sv | 40 ++++
 rtl/tt_check_settle_timer.sv | 48 ++++
 rtl/tt_response_checker.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/tt_check_pkg.sv
// Shared definitions for the truth-table response checker.
//
// Contents:
//   state_t / ST_*   FSM encodings (IDLE, ARMED, SETTLE, COMPARE, HALT)
//   tt_depth()       truth-table depth for a given stimulus width
//   cnt_max()        largest value of an unsigned counter of a given width
//   sat_inc()        saturating increment
package tt_check_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ARMED   = 3'd1;
  localparam state_t ST_SETTLE  = 3'd2;
  localparam state_t ST_COMPARE = 3'd3;
  localparam state_t ST_HALT    = 3'd4;

  localparam int TT_N_IN_DEFAULT = 2;

  function automatic int tt_depth(input int n_in);
    return 2 ** n_in;
  endfunction

  // Counters wider than 32 bits are not expected; clamp to all-ones.
  function automatic logic [31:0] cnt_max(input int width);
    if (width >= 32) begin
      return '1;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    if (value >= max_value) begin
      return max_value;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/tt_check_settle_timer.sv
// Settle-delay down-counter for the response checker.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset, clears the count
//   load_i     load SETTLE-1 (entry into the settle phase)
//   restart_i  reload SETTLE-1 (stimulus changed while settling)
//   run_i      decrement while the count is non-zero
//   expired_o  count has reached zero
module tt_check_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic restart_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(SETTLE - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // A load or restart always wins over decrementing so that a vector
  // change on the expiry cycle still restarts the full settle window.
  always_comb begin
    count_d = count_q;
    if (load_i || restart_i) begin
      count_d = LOAD_VAL;
    end else if (run_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/tt_response_checker.sv
// Receive-side scoreboard for combinational DUT tests. Each time the
// stimulus vector changes it waits SETTLE cycles, then compares the DUT
// result with a programmable truth table, counting checks and mismatches
// and capturing the first failing vector.
//
// Parameters: N_IN (stimulus width), SETTLE (>=1 cycles), CNT_W (counters)
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   tt_wr_en/addr/data  truth-table write port (one entry per cycle)
//   enable           1 = checking active, 0 = return to IDLE
//   in_vec, dut_y    stimulus applied to the DUT and its result
//   busy             settle countdown running
//   check_cnt        completed compares (saturating)
//   err_cnt          mismatching compares (saturating)
//   fail             sticky first-mismatch flag
//   first_err_vec    stimulus of the first mismatch
//
// Build option: define TT_CHECK_HALT_EN to stop in HALT on the first
// mismatch until reset.
module tt_response_checker
  import tt_check_pkg::*;
#(
  parameter int N_IN   = TT_N_IN_DEFAULT,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tt_wr_en,
  input  logic [N_IN-1:0] tt_wr_addr,
  input  logic            tt_wr_data,
  input  logic            enable,
  input  logic [N_IN-1:0] in_vec,
  input  logic            dut_y,
  output logic            busy,
  output logic [CNT_W-1:0] check_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic            fail,
  output logic [N_IN-1:0] first_err_vec
);

  localparam int          TT_DEPTH = tt_depth(N_IN);
  localparam logic [31:0] CNT_MAX  = cnt_max(CNT_W);

  state_t               state_q, state_d;
  logic                 first_q, first_d;
  logic [N_IN-1:0]      prev_vec_q, prev_vec_d;
  logic [TT_DEPTH-1:0]  tt_q, tt_d;
  logic [CNT_W-1:0]     check_cnt_q, check_cnt_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic                 fail_q, fail_d;
  logic [N_IN-1:0]      first_err_vec_q, first_err_vec_d;

  logic timerLoad;
  logic timerRestart;
  logic timerRun;
  logic timerExpired;
  logic vecChanged;
  logic mismatch;

  tt_check_settle_timer #(
    .SETTLE(SETTLE)
  ) u_settle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (timerLoad),
    .restart_i (timerRestart),
    .run_i     (timerRun),
    .expired_o (timerExpired)
  );

  assign vecChanged = (in_vec != prev_vec_q);

  // The compare reads the registered table, so a write landing in the
  // COMPARE cycle is checked against the old entry and applies afterwards.
  // The 4-state inequality makes an X/Z result count as a mismatch.
  assign mismatch = (dut_y !== tt_q[in_vec]);

  // Truth-table write port; open in every state.
  always_comb begin
    tt_d = tt_q;
    if (tt_wr_en) begin
      tt_d[tt_wr_addr] = tt_wr_data;
    end
  end

  // Checking FSM: wait for a vector change, let it settle, compare once.
  // The first ARMED cycle after IDLE counts as a change so the vector
  // already present at enable time is checked too.
  always_comb begin
    state_d         = state_q;
    first_d         = first_q;
    prev_vec_d      = prev_vec_q;
    check_cnt_d     = check_cnt_q;
    err_cnt_d       = err_cnt_q;
    fail_d          = fail_q;
    first_err_vec_d = first_err_vec_q;
    timerLoad       = 1'b0;
    timerRestart    = 1'b0;
    timerRun        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ARMED;
          first_d = 1'b1;
        end
      end

      ST_ARMED: begin
        prev_vec_d = in_vec;
        if (first_q || vecChanged) begin
          state_d   = ST_SETTLE;
          first_d   = 1'b0;
          timerLoad = 1'b1;
        end
      end

      ST_SETTLE: begin
        prev_vec_d = in_vec;
        timerRun   = 1'b1;
        if (vecChanged) begin
          timerRestart = 1'b1;
        end else if (timerExpired) begin
          state_d = ST_COMPARE;
        end
      end

      ST_COMPARE: begin
        state_d     = ST_ARMED;
        check_cnt_d = CNT_W'(sat_inc(32'(check_cnt_q), CNT_MAX));
        if (mismatch) begin
          err_cnt_d = CNT_W'(sat_inc(32'(err_cnt_q), CNT_MAX));
          if (!fail_q) begin
            fail_d          = 1'b1;
            first_err_vec_d = in_vec;
          end
`ifdef TT_CHECK_HALT_EN
          state_d = ST_HALT;
`endif
        end
      end

`ifdef TT_CHECK_HALT_EN
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Dropping enable abandons any pending compare; HALT ignores it and
    // is left only through reset.
    if (!enable && (state_q != ST_HALT) && (state_d != ST_HALT)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      first_q         <= 1'b0;
      prev_vec_q      <= '0;
      tt_q            <= '0;
      check_cnt_q     <= '0;
      err_cnt_q       <= '0;
      fail_q          <= 1'b0;
      first_err_vec_q <= '0;
    end else begin
      state_q         <= state_d;
      first_q         <= first_d;
      prev_vec_q      <= prev_vec_d;
      tt_q            <= tt_d;
      check_cnt_q     <= check_cnt_d;
      err_cnt_q       <= err_cnt_d;
      fail_q          <= fail_d;
      first_err_vec_q <= first_err_vec_d;
    end
  end

  assign busy          = (state_q == ST_SETTLE);
  assign check_cnt     = check_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign fail          = fail_q;
  assign first_err_vec = first_err_vec_q;

endmodule
